// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared state encoding and default timing constants for the shift input conditioner
package shift_pkg;

  typedef enum logic {
    SC_IDLE    = 1'b0,
    SC_LOCKOUT = 1'b1
  } sc_state_t;

  localparam int DB_CYCLES_DEF      = 16;
  localparam int LOCKOUT_CYCLES_DEF = 8;
  localparam int REPEAT_CYCLES_DEF  = 64;

endpackage

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - one channel: 2-flop synchroniser plus stable-count debouncer
// quiet flags a confirmed-low input once the synchroniser has refilled after reset.
module input_debouncer
  import shift_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic quiet
);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fill_q, fill_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    fill_d  = {fill_q[0], 1'b1};
    db_d    = db_q;
    cnt_d   = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES)) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
      fill_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

  assign db = db_q;
  // Reset values in the synchroniser are not real observations, so wait until it has refilled.
  assign quiet = fill_q[1] & ~sync2_q & ~db_q;

endmodule

// File: rtl/shift_input_conditioner.sv
// rtl/shift_input_conditioner.sv - paddle/brake front end: debounce, arming, shift pulses with lockout
// Optional auto-repeat of a held paddle is enabled by defining SHIFT_AUTOREPEAT_EN.
module shift_input_conditioner
  import shift_pkg::*;
#(
  parameter int DB_CYCLES      = DB_CYCLES_DEF,
  parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF,
  parameter int REPEAT_CYCLES  = REPEAT_CYCLES_DEF,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  input  logic brake_raw,
  output logic shift_up,
  output logic shift_down,
  output logic brake,
  output logic busy
);

  logic up_db, dn_db, up_quiet, dn_quiet, br_quiet_unused;

  input_debouncer #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_up (
    .clk(clk), .reset(reset), .raw(btn_up_raw), .db(up_db), .quiet(up_quiet));
  input_debouncer #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_dn (
    .clk(clk), .reset(reset), .raw(btn_down_raw), .db(dn_db), .quiet(dn_quiet));
  input_debouncer #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_br (
    .clk(clk), .reset(reset), .raw(brake_raw), .db(brake), .quiet(br_quiet_unused));

  sc_state_t        state_q, state_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             up_prev_q, up_prev_d, dn_prev_q, dn_prev_d;
  logic             up_arm_q, up_arm_d, dn_arm_q, dn_arm_d;
  logic             shift_up_q, shift_up_d, shift_down_q, shift_down_d;
  logic             busy_q, busy_d;
  logic             up_req, dn_req, fire_up, fire_dn;

`ifdef SHIFT_AUTOREPEAT_EN
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             held_up, held_dn, rep_hit;
`else
  logic [CNT_W-1:0] rep_unused;
  assign rep_unused = CNT_W'(REPEAT_CYCLES);
`endif

  always_comb begin
    up_req    = up_arm_q & up_db & ~up_prev_q;
    dn_req    = dn_arm_q & dn_db & ~dn_prev_q;
    fire_up   = up_req & ~dn_req;
    fire_dn   = dn_req & ~up_req;
    up_prev_d = up_db;
    dn_prev_d = dn_db;
    up_arm_d  = up_arm_q | up_quiet;
    dn_arm_d  = dn_arm_q | dn_quiet;
`ifdef SHIFT_AUTOREPEAT_EN
    held_up   = up_arm_q & up_db & ~dn_db;
    held_dn   = dn_arm_q & dn_db & ~up_db;
    rep_hit   = rep_cnt_q >= CNT_W'(REPEAT_CYCLES - 1);
    fire_up   = fire_up | (held_up & rep_hit);
    fire_dn   = fire_dn | (held_dn & rep_hit);
    // Counter runs through lockout so the period is measured from the previous pulse.
    if (!(held_up | held_dn)) begin
      rep_cnt_d = '0;
    end else if (state_q == SC_IDLE && (fire_up | fire_dn)) begin
      rep_cnt_d = '0;
    end else if (!rep_hit) begin
      rep_cnt_d = rep_cnt_q + 1'b1;
    end else begin
      rep_cnt_d = rep_cnt_q;
    end
`endif
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    shift_up_d   = 1'b0;
    shift_down_d = 1'b0;
    busy_d       = busy_q;
    case (state_q)
      SC_IDLE: begin
        busy_d = 1'b0;
        if (fire_up || fire_dn) begin
          shift_up_d   = fire_up;
          shift_down_d = fire_dn;
          lock_cnt_d   = CNT_W'(LOCKOUT_CYCLES);
          state_d      = SC_LOCKOUT;
        end
      end
      default: begin
        if (lock_cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = SC_IDLE;
        end else begin
          busy_d     = 1'b1;
          lock_cnt_d = lock_cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SC_IDLE;
      lock_cnt_q   <= '0;
      up_prev_q    <= 1'b0;
      dn_prev_q    <= 1'b0;
      up_arm_q     <= 1'b0;
      dn_arm_q     <= 1'b0;
      shift_up_q   <= 1'b0;
      shift_down_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SHIFT_AUTOREPEAT_EN
      rep_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      up_prev_q    <= up_prev_d;
      dn_prev_q    <= dn_prev_d;
      up_arm_q     <= up_arm_d;
      dn_arm_q     <= dn_arm_d;
      shift_up_q   <= shift_up_d;
      shift_down_q <= shift_down_d;
      busy_q       <= busy_d;
`ifdef SHIFT_AUTOREPEAT_EN
      rep_cnt_q    <= rep_cnt_d;
`endif
    end
  end

  assign shift_up   = shift_up_q;
  assign shift_down = shift_down_q;
  assign busy       = busy_q;

endmodule
